// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core.
// Every output is a register or a decode of the state register.
module npc_ctrl_fsm #(
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        if_req_valid,
   input  logic        if_req_ready,
   input  logic        if_resp_valid,
   input  logic [31:0] if_resp_inst,
   output logic [31:0] inst_q,
   input  logic        dec_load,
   input  logic        dec_store,
   input  logic        dec_ebreak,
   input  logic        dec_inv,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_resp_valid,
   output logic        rf_wen,
   output logic        pc_wen,
   output logic        halted,
   output logic [1:0]  trap_code,
   output logic [3:0]  state_o
);

   // state    | meaning
   // RST      | leaving reset, nothing requested yet
   // IF_REQ   | fetch request held until accepted
   // IF_WAIT  | fetch accepted, waiting for the instruction word
   // ID       | decoder settles on inst_q
   // EX       | decode flags sampled, route to halt/memory/writeback
   // MEM_REQ  | data-memory request held until accepted
   // MEM_WAIT | data-memory request accepted, waiting for completion
   // WB       | single-cycle PC / register-file write
   // HALT     | absorbing stop state, trap_code held
   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_IF_REQ   = 4'd1,
      S_IF_WAIT  = 4'd2,
      S_ID       = 4'd3,
      S_EX       = 4'd4,
      S_MEM_REQ  = 4'd5,
      S_MEM_WAIT = 4'd6,
      S_WB       = 4'd7,
      S_HALT     = 4'd8
   } state_t;

   localparam logic [1:0] TRAP_EBREAK  = 2'd1;
   localparam logic [1:0] TRAP_INV     = 2'd2;
   localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

   // The last wait cycle is TIMEOUT-1 because the counter starts at zero on entry.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_MAX  = '1;

   state_t            state_q, state_d;
   logic [31:0]       inst_d;
   logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [1:0]        trap_q, trap_d;
   logic              store_q, store_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RST;
         inst_q  <= '0;
         cnt_q   <= '0;
         trap_q  <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         store_q <= store_d;
      end
   end

   assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      trap_d  = trap_q;
      store_d = store_q;
      unique case (state_q)
         S_RST: state_d = S_IF_REQ;
         S_IF_REQ: begin
            if (if_req_ready) begin
               if (if_resp_valid) begin
                  inst_d  = if_resp_inst;
                  state_d = S_ID;
               end else begin
                  cnt_d   = '0;
                  state_d = S_IF_WAIT;
               end
            end
         end
         S_IF_WAIT: begin
            if (if_resp_valid) begin
               inst_d  = if_resp_inst;
               state_d = S_ID;
            end else if (cnt_q == TO_LAST) begin
               trap_d  = TRAP_TIMEOUT;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_ID: state_d = S_EX;
         S_EX: begin
            // Store flag is captured so rf_wen in WB depends only on registers.
            store_d = dec_store;
            if (dec_ebreak) begin
               trap_d  = TRAP_EBREAK;
               state_d = S_HALT;
            end else if (dec_inv || (dec_load && dec_store)) begin
               trap_d  = TRAP_INV;
               state_d = S_HALT;
            end else if (dec_load || dec_store) begin
               state_d = S_MEM_REQ;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM_REQ: begin
            if (lsu_req_ready) begin
               if (lsu_resp_valid) begin
                  state_d = S_WB;
               end else begin
                  cnt_d   = '0;
                  state_d = S_MEM_WAIT;
               end
            end
         end
         S_MEM_WAIT: begin
            if (lsu_resp_valid) begin
               state_d = S_WB;
            end else if (cnt_q == TO_LAST) begin
               trap_d  = TRAP_TIMEOUT;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WB:   state_d = S_IF_REQ;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   assign if_req_valid  = (state_q == S_IF_REQ);
   assign lsu_req_valid = (state_q == S_MEM_REQ);
   assign pc_wen        = (state_q == S_WB);
   assign rf_wen        = (state_q == S_WB) && !store_q;
   assign halted        = (state_q == S_HALT);
   assign trap_code     = trap_q;
   assign state_o       = state_q;

endmodule
